// File: rtl/cdb_arbiter_rr.sv
// Round-robin common-data-bus arbiter: forwards at most one EU result per cycle.
// Define LEN5_CDB_OUT_REG_EN to add the registered output stage (1-cycle latency).

package expipe_pkg;
  localparam int unsigned EU_N      = 4;
  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned VALUE_W   = 64;
  localparam int unsigned EXCEPT_W  = 5;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [VALUE_W-1:0]   res_value;
    logic                 except_raised;
    logic [EXCEPT_W-1:0]  except_code;
  } cdb_data_t;
endpackage

module cdb_arbiter_rr
  import expipe_pkg::cdb_data_t;
#(
  parameter int unsigned EU_N  = expipe_pkg::EU_N,
  parameter int unsigned IDX_W = $clog2(EU_N)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [EU_N-1:0]      eu_valid_i,
  output logic [EU_N-1:0]      eu_ready_o,
  input  cdb_data_t [EU_N-1:0] eu_data_i,
  output logic                 cdb_valid_o,
  input  logic                 cdb_ready_i,
  output cdb_data_t            cdb_data_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EU_N - 1);
  localparam logic [IDX_W:0]   EU_N_EXT = (IDX_W+1)'(EU_N);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W:0]   w_cand;
  logic [EU_N-1:0]  w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_found;
  logic             w_accept;
  logic             w_xfer;

  // Search starts one past the last winner; EU_N need not be a power of two.
  assign w_start = (r_last == LAST_IDX) ? '0 : IDX_W'(r_last + IDX_W'(1));

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int unsigned i = 0; i < EU_N; i++) begin
      w_cand = (IDX_W+1)'({1'b0, w_start} + (IDX_W+1)'(i));
      if (w_cand >= EU_N_EXT) begin
        w_cand = (IDX_W+1)'(w_cand - EU_N_EXT);
      end
      if (!w_found && eu_valid_i[w_cand[IDX_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[IDX_W-1:0];
      end
    end
    w_grant[w_grant_idx] = w_found;
  end

`ifdef LEN5_CDB_OUT_REG_EN
  logic      r_out_valid;
  cdb_data_t r_out_data;

  // Output register may be refilled in the same cycle it drains.
  assign w_accept = !r_out_valid || cdb_ready_i;
`else
  assign w_accept = cdb_ready_i;
`endif

  // Ready is suppressed during reset so no EU sees a handshake that never lands.
  assign eu_ready_o = w_grant & {EU_N{w_accept && !flush_i && rst_ni}};
  assign w_xfer     = w_found && w_accept && !flush_i && rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last <= LAST_IDX;
    end else if (w_xfer) begin
      r_last <= w_grant_idx;
    end
  end

`ifdef LEN5_CDB_OUT_REG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= eu_data_i[w_grant_idx];
    end else if (cdb_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cdb_valid_o = r_out_valid && !flush_i && rst_ni;
  assign cdb_data_o  = r_out_data;
`else
  assign cdb_valid_o = (|eu_valid_i) && !flush_i && rst_ni;
  assign cdb_data_o  = eu_data_i[w_grant_idx];
`endif

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Self-checking bench for cdb_arbiter_rr (EU_N=4), both with and without LEN5_CDB_OUT_REG_EN.

module tb_cdb_arbiter_rr;
  import expipe_pkg::cdb_data_t;

  localparam int NEU = 4;

  logic            clk_i;
  logic            rst_ni;
  logic            flush_i;
  logic [3:0]      eu_valid_i;
  logic [3:0]      eu_ready_o;
  cdb_data_t [3:0] eu_data_i;
  logic            cdb_valid_o;
  logic            cdb_ready_i;
  cdb_data_t       cdb_data_o;

  cdb_arbiter_rr #(.EU_N(NEU)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .eu_valid_i (eu_valid_i),
    .eu_ready_o (eu_ready_o),
    .eu_data_i  (eu_data_i),
    .cdb_valid_o(cdb_valid_o),
    .cdb_ready_i(cdb_ready_i),
    .cdb_data_o (cdb_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          errs;
  int          checks;
  bit          chk_en;
  bit          sb_en;
  int          m_last;
`ifdef LEN5_CDB_OUT_REG_EN
  logic        m_out_valid;
  cdb_data_t   m_out_data;
`endif
  logic [63:0] sbq[$];
  int          wait_cnt [NEU];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: first valid EU scanning upward from the previous winner, modulo EU count.
  function automatic int exp_k();
    for (int o = 1; o <= NEU; o++) begin
      if (eu_valid_i[(m_last + o) % NEU]) return (m_last + o) % NEU;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int   k;
    logic acc;
    k = exp_k();
`ifdef LEN5_CDB_OUT_REG_EN
    acc = !m_out_valid || cdb_ready_i;
`else
    acc = cdb_ready_i;
`endif
    if (k < 0 || !acc || flush_i || !rst_ni) return 4'b0000;
    return 4'b0001 << k;
  endfunction

  // Model state update on the active edge.
  always @(posedge clk_i) begin
    int         k;
    logic [3:0] er;
    k  = exp_k();
    er = exp_ready();
    if (!rst_ni) begin
      m_last = NEU - 1;
`ifdef LEN5_CDB_OUT_REG_EN
      m_out_valid = 1'b0;
      m_out_data  = '0;
`endif
    end else begin
      if (er != 4'b0000) m_last = k;
`ifdef LEN5_CDB_OUT_REG_EN
      if (flush_i) m_out_valid = 1'b0;
      else if (er != 4'b0000) begin
        m_out_valid = 1'b1;
        m_out_data  = eu_data_i[k];
      end else if (cdb_ready_i) m_out_valid = 1'b0;
`endif
    end
  end

  // Per-cycle comparison of DUT outputs with the model, plus scoreboard and fairness.
  always @(negedge clk_i) begin
    int         ck;
    logic [3:0] er;
    logic       ev;
    cdb_data_t  ed;
    logic [63:0] front;
    #2;
    if (chk_en) begin
      ck = exp_k();
      er = exp_ready();
`ifdef LEN5_CDB_OUT_REG_EN
      ev = rst_ni && !flush_i && m_out_valid;
      ed = m_out_data;
`else
      ev = rst_ni && !flush_i && (eu_valid_i != 4'b0000);
      ed = (ck < 0) ? cdb_data_t'(0) : eu_data_i[ck];
`endif
      check("eu_ready_o", 128'(eu_ready_o), 128'(er));
      check("cdb_valid_o", 128'(cdb_valid_o), 128'(ev));
      if (ev) check("cdb_data_o", 128'(cdb_data_o), 128'(ed));
      if (sb_en) begin
        if (er != 4'b0000) begin
          sbq.push_back(eu_data_i[ck].res_value);
          checks++;
          if (wait_cnt[ck] >= NEU) begin
            errs++;
            $display("FAIL starvation: EU%0d waited %0d transfers, limit %0d", ck, wait_cnt[ck], NEU - 1);
          end
          for (int j = 0; j < NEU; j++) begin
            if (j == ck) wait_cnt[j] = 0;
            else if (eu_valid_i[j]) wait_cnt[j]++;
          end
        end
        for (int j = 0; j < NEU; j++) if (!eu_valid_i[j]) wait_cnt[j] = 0;
        if (cdb_valid_o && cdb_ready_i) begin
          if (sbq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL delivery: actual=%0h required=none pending", cdb_data_o.res_value);
          end else begin
            front = sbq.pop_front();
            check("delivery", 128'(cdb_data_o.res_value), 128'(front));
          end
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic [3:0] v, input logic rdy);
    @(negedge clk_i);
    rst_ni      = r;
    flush_i     = f;
    eu_valid_i  = v;
    cdb_ready_i = rdy;
    #1;
  endtask

  logic [3:0] rdy_exp [5];
  int         pri_g   [5];
  logic [3:0] pend;
  int         tag;

  initial begin
    errs = 0; checks = 0; chk_en = 0; sb_en = 0;
    m_last = NEU - 1;
`ifdef LEN5_CDB_OUT_REG_EN
    m_out_valid = 1'b0;
    m_out_data  = '0;
`endif
    for (int j = 0; j < NEU; j++) wait_cnt[j] = 0;
    rst_ni = 1'b0; flush_i = 1'b0; eu_valid_i = 4'b0000; cdb_ready_i = 1'b0;
    for (int k = 0; k < NEU; k++) begin
      eu_data_i[k].rob_idx       = 6'(10 + k);
      eu_data_i[k].res_value     = 64'h1000 + 64'(k);
      eu_data_i[k].except_raised = 1'b0;
      eu_data_i[k].except_code   = 5'd0;
    end
    cyc(1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0);
    chk_en = 1;

    // Reset state
    cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    check("rst_ready", 128'(eu_ready_o), 128'(4'b0000));
    check("rst_valid", 128'(cdb_valid_o), 128'(1'b0));
`ifdef LEN5_CDB_OUT_REG_EN
    check("rst_data", 128'(cdb_data_o), 128'(0));
`endif

    // Post-reset priority: 0,1,2,3,0
    rdy_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pri_g   = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 4'b1111, 1'b1);
      check("pri_ready", 128'(eu_ready_o), 128'(rdy_exp[i]));
`ifdef LEN5_CDB_OUT_REG_EN
      if (i == 0) check("pri_valid0", 128'(cdb_valid_o), 128'(1'b0));
      else begin
        check("pri_valid", 128'(cdb_valid_o), 128'(1'b1));
        check("pri_rob_idx", 128'(cdb_data_o.rob_idx), 128'(10 + pri_g[i-1]));
      end
`else
      check("pri_valid", 128'(cdb_valid_o), 128'(1'b1));
      check("pri_rob_idx", 128'(cdb_data_o.rob_idx), 128'(10 + pri_g[i]));
`endif
    end

    // Wrap-around: EU2 wins, then 0011 grants EU0 then EU1, EU3 skipped
    cyc(1'b1, 1'b0, 4'b0100, 1'b1);
    check("wrap_ready_eu2", 128'(eu_ready_o), 128'(4'b0100));
    cyc(1'b1, 1'b0, 4'b0011, 1'b1);
    check("wrap_ready_eu0", 128'(eu_ready_o), 128'(4'b0001));
    cyc(1'b1, 1'b0, 4'b0011, 1'b1);
    check("wrap_ready_eu1", 128'(eu_ready_o), 128'(4'b0010));

    // Back-pressure on EU1 carrying 0xDEAD
    cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    eu_data_i[1].res_value = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 4'b0010, 1'b0);
`ifdef LEN5_CDB_OUT_REG_EN
      if (i == 0) begin
        check("bp_load_ready", 128'(eu_ready_o), 128'(4'b0010));
        check("bp_load_valid", 128'(cdb_valid_o), 128'(1'b0));
      end else begin
        check("bp_hold_ready", 128'(eu_ready_o), 128'(4'b0000));
        check("bp_hold_valid", 128'(cdb_valid_o), 128'(1'b1));
        check("bp_hold_data", 128'(cdb_data_o.res_value), 128'(64'hDEAD));
      end
`else
      check("bp_hold_ready", 128'(eu_ready_o), 128'(4'b0000));
      check("bp_hold_valid", 128'(cdb_valid_o), 128'(1'b1));
      check("bp_hold_data", 128'(cdb_data_o.res_value), 128'(64'hDEAD));
`endif
    end
    cyc(1'b1, 1'b0, 4'b0010, 1'b1);
    check("bp_release_ready", 128'(eu_ready_o), 128'(4'b0010));
    check("bp_release_data", 128'(cdb_data_o.res_value), 128'(64'hDEAD));

    // Flush while the output holds a result; pointer must survive
    cyc(1'b1, 1'b0, 4'b0100, 1'b1);
    check("fl_pre_ready", 128'(eu_ready_o), 128'(4'b0100));
    cyc(1'b1, 1'b1, 4'b0001, 1'b1);
    check("fl_ready", 128'(eu_ready_o), 128'(4'b0000));
    check("fl_valid", 128'(cdb_valid_o), 128'(1'b0));
    cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    check("fl_next_valid", 128'(cdb_valid_o), 128'(1'b0));
    cyc(1'b1, 1'b0, 4'b1111, 1'b1);
    check("fl_ptr_kept", 128'(eu_ready_o), 128'(4'b1000));

    // Reset in the middle of streaming
    cyc(1'b1, 1'b0, 4'b1111, 1'b1);
    check("rm_stream", 128'(eu_ready_o), 128'(4'b0001));
    cyc(1'b0, 1'b0, 4'b1111, 1'b1);
    check("rm_rst_ready", 128'(eu_ready_o), 128'(4'b0000));
    check("rm_rst_valid", 128'(cdb_valid_o), 128'(1'b0));
    cyc(1'b1, 1'b0, 4'b1111, 1'b1);
    check("rm_grant_eu0", 128'(eu_ready_o), 128'(4'b0001));
`ifdef LEN5_CDB_OUT_REG_EN
    check("rm_valid_after", 128'(cdb_valid_o), 128'(1'b0));
`endif

    // Random traffic with protocol-respecting EUs
    cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    sbq.delete();
    for (int j = 0; j < NEU; j++) wait_cnt[j] = 0;
    sb_en = 1;
    pend = 4'b0000;
    tag = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < NEU; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1'b1;
          tag++;
          eu_data_i[k].rob_idx   = 6'(tag);
          eu_data_i[k].res_value = {32'(k), 32'(tag)};
        end
      end
      rst_ni      = 1'b1;
      flush_i     = 1'b0;
      eu_valid_i  = pend;
      cdb_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      pend = pend & ~(eu_valid_i & eu_ready_o);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'b0000, 1'b1);
    check("sb_drained", 128'(sbq.size()), 128'(0));

    chk_en = 0;
    sb_en  = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
